psum_accumulator: RTL
=====================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter ACC_W, default 40: internal signed accumulator width.
REQ-002 Parameter CNT_W, default 16: width of term and group counters.
REQ-003 Parameter OUT_DEPTH, default 2: result FIFO depth, a power of two, at least 2.
REQ-004 Ports clk (input, 1) and rst (input, 1): one clock, rising edge. Reset is synchronous and active-high.
REQ-005 Port start (input, 1): one-cycle pulse that launches a job.
REQ-006 Port cfg_len (input, CNT_W): products per dot product (K). Sampled on an accepted start.
REQ-007 Port cfg_groups (input, CNT_W): number of dot products in the job. Sampled on an accepted start.
REQ-008 Port prod_valid (input, 1): a multiply-element product is present.
REQ-009 Port prod (input, 32, signed): the product value.
REQ-010 Port prod_ready (output, 1): the block accepts the product this cycle.
REQ-011 Port out_valid (output, 1): a result is available at the FIFO head.
REQ-012 Port out_data (output, 32, signed): the saturated result.
REQ-013 Port out_sat (output, 1): the head result was saturated.
REQ-014 Port out_ready (input, 1): the consumer takes the head result.
REQ-015 Port busy (output, 1): a job is in progress.
REQ-016 Port done (output, 1): one-cycle pulse at job completion.
REQ-017 Port cfg_err (output, 1): one-cycle pulse when a start is rejected for a zero length or zero group count.

Function
REQ-018 The block SHALL be a two-state FSM with states IDLE and ACC.
REQ-019 In IDLE, start with cfg_len!=0 and cfg_groups!=0 SHALL latch both values, clear the accumulator and both counters, and enter ACC on the next edge.
REQ-020 In IDLE, start with cfg_len==0 or cfg_groups==0 SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-021 start asserted while in ACC SHALL be ignored, with no cfg_err.
REQ-022 prod_ready SHALL equal (state==ACC) AND (FIFO not full), combinationally.
REQ-023 A product is accepted when prod_valid and prod_ready are both high; prod_valid while prod_ready is low SHALL have no effect.
REQ-024 On each accepted product, the product SHALL be sign-extended to ACC_W bits and added to the accumulator, and the term counter SHALL increment.
REQ-025 On the accepted product that brings the term count to cfg_len, the final sum SHALL be pushed to the FIFO that same edge.
 - The pushed sum includes that last product.
 - The accumulator and term counter clear, and the group counter increments.
 - The result is visible on out_valid on the next cycle (one-cycle latency from the last accepted product).
REQ-026 Saturation SHALL be applied on push.
 - A sum above 2^31-1 is stored as 0x7FFFFFFF with its sat bit set to 1.
 - A sum below -2^31 is stored as 0x80000000 with its sat bit set to 1.
 - Any other sum is stored truncated to 32 bits with its sat bit set to 0.
REQ-027 Accumulator overflow within ACC_W bits is not detected; integrators SHALL keep cfg_len at or below 2^(ACC_W-32).
REQ-028 When the push completes group cfg_groups, the FSM SHALL return to IDLE and pulse done in the same cycle the FSM state becomes IDLE.
REQ-029 busy SHALL equal (state==ACC).
REQ-030 The FIFO SHALL pop when out_valid and out_ready are both high. out_data and out_sat SHALL hold stable while out_valid is high and out_ready is low.
REQ-031 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged, with correct ordering.
REQ-032 When the FIFO is full, prod_ready SHALL be low. A pop in that cycle SHALL raise prod_ready on the following cycle; there is no combinational path from out_ready to prod_ready.
REQ-033 out_ready asserted while the FIFO is empty SHALL have no effect.
REQ-034 Results left in the FIFO after done SHALL remain poppable in IDLE.

Reset
REQ-035 rst SHALL be sampled on the clk edge and take priority over all other inputs.
REQ-036 On reset, the following SHALL be cleared:
 - FSM state to IDLE.
 - Accumulator, term counter and group counter to 0.
 - FIFO pointers and count to 0.
 - Latched cfg_len and cfg_groups to 0.
REQ-037 Outputs in reset and on the first cycle after it SHALL be: prod_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0, done=0, cfg_err=0.
REQ-038 Reset asserted mid-job SHALL discard the partial sum and all queued results.

Structure
REQ-039 A shared package SHALL hold:
 - the FSM state enum;
 - the constants INT32_MAX and INT32_MIN;
 - the default values of ACC_W and CNT_W.
REQ-040 The result FIFO SHALL be a sub-module named psum_fifo (synchronous FIFO, 33 bits wide to carry data plus sat, depth OUT_DEPTH). The FSM and saturation logic stay in the top module.

Verification
REQ-041 Set cfg_len=4, cfg_groups=1, then send products 3, -5, 7, 10 back-to-back with out_ready=1. Expected: out_data=15, out_sat=0, and done pulses once.
REQ-042 Set cfg_len=2 and send 0x7FFFFFFF twice. Expected: out_data=0x7FFFFFFF and out_sat=1. Repeat with 0x80000000 twice. Expected: out_data=0x80000000 and out_sat=1.
REQ-043 Set cfg_len=1, cfg_groups=4, send products 1..4, and hold out_ready=0.
 - Expected: prod_ready drops after the 2nd push.
 - Then raise out_ready. Expected: outputs appear in order 1, 2, 3, 4, with no loss or duplication.
REQ-044 Pulse start with cfg_len=0. Expected: cfg_err pulses for 1 cycle, busy stays 0, and no output appears.
REQ-045 Set cfg_len=8, accept 3 products, then assert rst for 1 cycle. Expected: busy=0 and out_valid=0.
 - Then start a new job with cfg_len=2 and send products 6, 6. Expected: out_data=12.
REQ-046 Apply random prod_valid and out_ready gaps across cfg_groups=16. Expected: results match a reference sum model, and done pulses exactly once.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared types and constants for the partial-sum accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_accumulator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

    localparam int ACC_W_DEFAULT = 40;
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO with first-word-fall-through head; head reads as zero when empty.
// Latency: a pushed word is visible at the head on the cycle after the push edge.
// Backpressure: full blocks pushes, empty blocks pops; push and pop together keep occupancy.
module psum_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    // Zeroed head keeps the downstream data bus clean while nothing is queued.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates signed 32-bit products into K-term dot products, saturates each to 32 bits and queues it.
// Latency: result at the FIFO head one cycle after the last accepted product of a group.
// Backpressure: prod_ready falls while the result FIFO is full; out_valid/out_ready drains the FIFO.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int OUT_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_len,
    input  logic [CNT_W-1:0]        cfg_groups,
    input  logic                    prod_valid,
    input  logic signed [31:0]      prod,
    output logic                    prod_ready,
    output logic                    out_valid,
    output logic signed [31:0]      out_data,
    output logic                    out_sat,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(INT32_MAX);
    localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(INT32_MIN);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        groups_q;
    logic [CNT_W-1:0]        term_q;
    logic [CNT_W-1:0]        grp_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    done_q;
    logic                    cfg_err_q;

    logic                    cfg_ok;
    logic                    start_ok;
    logic                    start_bad;
    logic                    accept;
    logic                    last_term;
    logic                    last_group;
    logic [CNT_W-1:0]        term_inc;
    logic [CNT_W-1:0]        grp_inc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_d;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [32:0]             push_word;
    logic [32:0]             head_word;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign cfg_ok     = (cfg_len != '0) && (cfg_groups != '0);
    assign start_ok   = (state_q == IDLE) && start && cfg_ok;
    assign start_bad  = (state_q == IDLE) && start && !cfg_ok;

    // Ready depends only on registered state, so out_ready never reaches it combinationally.
    assign prod_ready = (state_q == ACC) && !fifo_full;
    assign accept     = prod_valid && prod_ready;

    assign prod_ext   = {{(ACC_W-32){prod[31]}}, prod};
    assign sum_d      = acc_q + prod_ext;
    assign term_inc   = term_q + CNT_W'(1);
    assign grp_inc    = grp_q + CNT_W'(1);
    assign last_term  = accept && (term_inc == len_q);
    assign last_group = last_term && (grp_inc == groups_q);

    // The pushed sum already includes the product accepted on this edge.
    assign sat_hi     = (sum_d > MAX_EXT);
    assign sat_lo     = (sum_d < MIN_EXT);
    assign push_word  = sat_hi ? {1'b1, INT32_MAX} :
                        sat_lo ? {1'b1, INT32_MIN} :
                                 {1'b0, sum_d[31:0]};

    assign out_valid  = !fifo_empty;
    assign out_sat    = head_word[32];
    assign out_data   = head_word[31:0];
    assign busy       = (state_q == ACC);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

    psum_fifo #(
        .WIDTH (33),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (last_term),
        .push_data (push_word),
        .pop       (out_ready),
        .head_data (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: launch on a valid start, finish on the push that closes the last group.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok)   state_d = ACC;
            ACC:     if (last_group) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: job config latch, running sum, term/group counters and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            groups_q  <= '0;
            term_q    <= '0;
            grp_q     <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= last_group;
            cfg_err_q <= start_bad;
            if (start_ok) begin
                len_q    <= cfg_len;
                groups_q <= cfg_groups;
                term_q   <= '0;
                grp_q    <= '0;
                acc_q    <= '0;
            end else if (accept) begin
                if (last_term) begin
                    acc_q  <= '0;
                    term_q <= '0;
                    grp_q  <= grp_inc;
                end else begin
                    acc_q  <= sum_d;
                    term_q <= term_inc;
                end
            end
        end
    end

endmodule
